// File: rtl/hp_link_core_if.sv
// hp_link_core_if: byte-wide PIPE-style symbol bus between the link core and
// the far-end (root-port BFM) side.
//   pipe_txdata  / pipe_txdatak : symbol and K flag sent by the core
//   pipe_rxdata  / pipe_rxdatak : symbol and K flag received by the core
//   pipe_rxvalid                : received symbol valid
// Modports: master = link core, slave = far-end driver.
interface hp_link_core_if;
    logic [7:0] pipe_txdata;
    logic       pipe_txdatak;
    logic [7:0] pipe_rxdata;
    logic       pipe_rxdatak;
    logic       pipe_rxvalid;

    modport master (
        output pipe_txdata, pipe_txdatak,
        input  pipe_rxdata, pipe_rxdatak, pipe_rxvalid
    );

    modport slave (
        input  pipe_txdata, pipe_txdatak,
        output pipe_rxdata, pipe_rxdatak, pipe_rxvalid
    );
endinterface

// File: rtl/hp_link_core.sv
// hp_link_core: reduced PCIe LTSSM (detect -> polling -> L0) over a byte-wide
// PIPE symbol interface. Sends TS1/TS2 ordered sets, parses received sets and
// reports the training state on the sim/debug pins.
// Ports:
//   sysclk, pci_perst_n : clock (rising edge) and async active-low reset
//   test_in             : [0] fast quiet, [1] report Gen2 in L0, [5] hold in quiet
//   simu_mode_pipe      : 1 = symbols advance on sim_pipe_pclk_in only
//   sim_pipe_pclk_in    : symbol-enable strobe
//   sim_pipe_rate       : 00 = Gen1, 01 in L0 with test_in[1]
//   sim_ltssmstate      : current state code
//   pci_rx / pci_tx     : far-end presence / transmitter active
//   link_up             : 1 while in L0
//   pipe                : PIPE symbol bus (master side)
module hp_link_core #(
    parameter int unsigned QUIET_CYCLES = 16,
    parameter int unsigned FAST_QUIET   = 4,
    parameter int unsigned POLL_TIMEOUT = 4096,
    parameter int unsigned RX_TS_COUNT  = 8,
    parameter int unsigned TX_TS2_MIN   = 16
) (
    input  logic         sysclk,
    input  logic         pci_perst_n,
    input  logic [31:0]  test_in,
    input  logic         simu_mode_pipe,
    input  logic         sim_pipe_pclk_in,
    output logic [1:0]   sim_pipe_rate,
    output logic [4:0]   sim_ltssmstate,
    input  logic         pci_rx,
    output logic         pci_tx,
    output logic         link_up,
    hp_link_core_if.master pipe
);
    localparam int unsigned TW = $clog2(POLL_TIMEOUT + QUIET_CYCLES + 2);
    localparam int unsigned RW = $clog2(RX_TS_COUNT + 1);
    localparam int unsigned XW = $clog2(TX_TS2_MIN + 1);

    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_TIMEOUT - 1);
    localparam logic [TW-1:0] QUIET_LAST = TW'(QUIET_CYCLES - 1);
    localparam logic [TW-1:0] FAST_LAST  = TW'(FAST_QUIET - 1);
    localparam logic [RW-1:0] RX_FULL    = RW'(RX_TS_COUNT);
    localparam logic [XW-1:0] TX_FULL    = XW'(TX_TS2_MIN);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_TS1 = 8'h4A;
    localparam logic [7:0] SYM_TS2 = 8'h45;

    typedef enum logic [4:0] {
        DETECT_QUIET   = 5'h00,
        DETECT_ACTIVE  = 5'h01,
        POLLING_ACTIVE = 5'h02,
        POLLING_CONFIG = 5'h04,
        L0             = 5'h0F
    } ltssm_e;

    ltssm_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    tx_ptr_q, tx_ptr_d;
    logic [XW-1:0] tx_ts2_q, tx_ts2_d;
    logic [RW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rx_in_set_q, rx_in_set_d;
    logic [3:0]    rx_pos_q, rx_pos_d;
    logic          rx_is_ts2_q, rx_is_ts2_d;
    logic [7:0]    txdata_q, txdata_d;
    logic          txdatak_q, txdatak_d;
    logic          pci_tx_q, pci_tx_d;
    logic          link_up_q, link_up_d;
    logic [1:0]    rate_q, rate_d;

    logic          tick;
    logic          polling;
    logic          hold;
    logic [TW-1:0] quiet_last;
    logic [TW-1:0] timer_inc;
    logic          unused_test_bits;

    assign tick       = simu_mode_pipe ? sim_pipe_pclk_in : 1'b1;
    assign polling    = (state_q == POLLING_ACTIVE) || (state_q == POLLING_CONFIG);
    assign hold       = (state_q == DETECT_QUIET) && test_in[5];
    assign quiet_last = test_in[0] ? FAST_LAST : QUIET_LAST;
    assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    assign unused_test_bits = ^{test_in[31:6], test_in[4:2]};

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        tx_ptr_d    = tx_ptr_q;
        tx_ts2_d    = tx_ts2_q;
        rx_cnt_d    = rx_cnt_q;
        rx_in_set_d = rx_in_set_q;
        rx_pos_d    = rx_pos_q;
        rx_is_ts2_d = rx_is_ts2_q;

        if (tick) begin
            case (state_q)
                DETECT_QUIET: begin
                    if (!test_in[5] && timer_q >= quiet_last) state_d = DETECT_ACTIVE;
                end
                DETECT_ACTIVE: state_d = pci_rx ? POLLING_ACTIVE : DETECT_QUIET;
                POLLING_ACTIVE: begin
                    if (!pci_rx || timer_q >= POLL_LAST) state_d = DETECT_QUIET;
                    else if (rx_cnt_q >= RX_FULL)        state_d = POLLING_CONFIG;
                end
                POLLING_CONFIG: begin
                    if (!pci_rx || timer_q >= POLL_LAST)                state_d = DETECT_QUIET;
                    else if (rx_cnt_q >= RX_FULL && tx_ts2_q >= TX_FULL) state_d = L0;
                end
                L0:      if (!pci_rx) state_d = DETECT_QUIET;
                default: state_d = DETECT_QUIET;
            endcase

            if (state_d != state_q) begin
                // Every state entry restarts timer, tx pointer and rx parser.
                timer_d     = '0;
                tx_ptr_d    = '0;
                tx_ts2_d    = '0;
                rx_cnt_d    = '0;
                rx_in_set_d = 1'b0;
                rx_pos_d    = '0;
                rx_is_ts2_d = 1'b0;
            end else begin
                if (!hold) timer_d = timer_inc;
                if (polling) begin
                    tx_ptr_d = tx_ptr_q + 4'd1;
                    // A TS2 counts as fully sent once its last symbol has been on the bus.
                    if (state_q == POLLING_CONFIG && tx_ptr_q == 4'hF && tx_ts2_q < TX_FULL)
                        tx_ts2_d = tx_ts2_q + 1'b1;

                    if (pipe.pipe_rxvalid) begin
                        if (pipe.pipe_rxdatak && pipe.pipe_rxdata == SYM_COM) begin
                            rx_in_set_d = 1'b1;
                            rx_pos_d    = 4'd1;
                        end else if (!rx_in_set_q) begin
                            rx_cnt_d = '0;
                        end else if (rx_pos_q == 4'd1) begin
                            if (!pipe.pipe_rxdatak &&
                                (pipe.pipe_rxdata == SYM_TS1 || pipe.pipe_rxdata == SYM_TS2)) begin
                                rx_is_ts2_d = (pipe.pipe_rxdata == SYM_TS2);
                                rx_pos_d    = 4'd2;
                            end else begin
                                rx_in_set_d = 1'b0;
                                rx_cnt_d    = '0;
                            end
                        end else if (!pipe.pipe_rxdatak &&
                                     pipe.pipe_rxdata == (rx_is_ts2_q ? SYM_TS2 : SYM_TS1)) begin
                            if (rx_pos_q == 4'hF) begin
                                rx_in_set_d = 1'b0;
                                rx_pos_d    = '0;
                                // In config a completed TS1 breaks the TS2 run.
                                if (state_q == POLLING_CONFIG && !rx_is_ts2_q) rx_cnt_d = '0;
                                else if (rx_cnt_q < RX_FULL)                     rx_cnt_d = rx_cnt_q + 1'b1;
                            end else begin
                                rx_pos_d = rx_pos_q + 4'd1;
                            end
                        end else begin
                            rx_in_set_d = 1'b0;
                            rx_cnt_d    = '0;
                        end
                    end
                end
            end
        end

        // Output registers are loaded from next-state values so they line up
        // with the state register.
        txdata_d  = '0;
        txdatak_d = 1'b0;
        if (state_d == POLLING_ACTIVE || state_d == POLLING_CONFIG) begin
            if (tx_ptr_d == 4'd0) begin
                txdata_d  = SYM_COM;
                txdatak_d = 1'b1;
            end else begin
                txdata_d  = (state_d == POLLING_CONFIG) ? SYM_TS2 : SYM_TS1;
            end
        end
        pci_tx_d  = (state_d != DETECT_QUIET) && (state_d != DETECT_ACTIVE);
        link_up_d = (state_d == L0);
        rate_d    = (state_d == L0 && test_in[1]) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge sysclk or negedge pci_perst_n) begin
        if (!pci_perst_n) begin
            state_q     <= DETECT_QUIET;
            timer_q     <= '0;
            tx_ptr_q    <= '0;
            tx_ts2_q    <= '0;
            rx_cnt_q    <= '0;
            rx_in_set_q <= 1'b0;
            rx_pos_q    <= '0;
            rx_is_ts2_q <= 1'b0;
            txdata_q    <= '0;
            txdatak_q   <= 1'b0;
            pci_tx_q    <= 1'b0;
            link_up_q   <= 1'b0;
            rate_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            tx_ptr_q    <= tx_ptr_d;
            tx_ts2_q    <= tx_ts2_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_in_set_q <= rx_in_set_d;
            rx_pos_q    <= rx_pos_d;
            rx_is_ts2_q <= rx_is_ts2_d;
            txdata_q    <= txdata_d;
            txdatak_q   <= txdatak_d;
            pci_tx_q    <= pci_tx_d;
            link_up_q   <= link_up_d;
            rate_q      <= rate_d;
        end
    end

    assign sim_ltssmstate    = state_q;
    assign sim_pipe_rate     = rate_q;
    assign pci_tx            = pci_tx_q;
    assign link_up           = link_up_q;
    assign pipe.pipe_txdata  = txdata_q;
    assign pipe.pipe_txdatak = txdatak_q;
endmodule

// File: tb/tb_hp_link_core.sv
// tb_hp_link_core: directed bench for hp_link_core with a far-end symbol
// driver, a per-tick behavioural model of the training rules and a compare
// process checking every output each cycle, plus literal expectations.
module tb_hp_link_core;
    logic        sysclk = 1'b0;
    logic        pci_perst_n;
    logic [31:0] test_in;
    logic        simu_mode_pipe;
    logic        sim_pipe_pclk_in;
    logic        pci_rx;
    logic [1:0]  sim_pipe_rate;
    logic [4:0]  sim_ltssmstate;
    logic        pci_tx;
    logic        link_up;

    hp_link_core_if pif();

    hp_link_core #(
        .QUIET_CYCLES(16), .FAST_QUIET(4), .POLL_TIMEOUT(4096),
        .RX_TS_COUNT(8), .TX_TS2_MIN(16)
    ) dut (
        .sysclk(sysclk), .pci_perst_n(pci_perst_n), .test_in(test_in),
        .simu_mode_pipe(simu_mode_pipe), .sim_pipe_pclk_in(sim_pipe_pclk_in),
        .sim_pipe_rate(sim_pipe_rate), .sim_ltssmstate(sim_ltssmstate),
        .pci_rx(pci_rx), .pci_tx(pci_tx), .link_up(link_up), .pipe(pif)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- symbol-enable strobe: every 4th cycle ----------------
    int phase = 0;
    initial begin
        sim_pipe_pclk_in = 1'b0;
        forever begin
            @(posedge sysclk);
            #1;
            phase++;
            sim_pipe_pclk_in = (phase % 4 == 0);
        end
    end

    // ---------------- far-end driver ----------------
    // type 0 = idle, 1 = TS1, 2 = TS2; queued types override the mode at set boundaries.
    int bfm_mode = 0;
    int bfm_q[$];
    int bfm_type = 0;
    int bfm_pos = 0;
    int ts2_since_ts1 = 0;

    task automatic drive_rx();
        if (bfm_type == 0) begin
            pif.pipe_rxvalid = 1'b0;
            pif.pipe_rxdata  = 8'h00;
            pif.pipe_rxdatak = 1'b0;
        end else begin
            pif.pipe_rxvalid = 1'b1;
            pif.pipe_rxdatak = (bfm_pos == 0);
            pif.pipe_rxdata  = (bfm_pos == 0) ? 8'hBC : ((bfm_type == 2) ? 8'h45 : 8'h4A);
        end
    endtask

    initial begin
        logic tk;
        drive_rx();
        forever begin
            @(posedge sysclk);
            tk = simu_mode_pipe ? sim_pipe_pclk_in : 1'b1;
            #1;
            if (tk) begin
                if (bfm_type != 0 && bfm_pos == 15) begin
                    if (bfm_type == 2) ts2_since_ts1++;
                    else ts2_since_ts1 = 0;
                end
                if (bfm_type == 0 || bfm_pos == 15) begin
                    bfm_pos = 0;
                    if (bfm_q.size() > 0) bfm_type = bfm_q.pop_front();
                    else bfm_type = bfm_mode;
                end else begin
                    bfm_pos++;
                end
                drive_rx();
            end
        end
    end

    // ---------------- behavioural model ----------------
    // m_n = ticks spent in the current state; tx symbol index is m_n mod 16 and
    // the number of fully sent sets is m_n / 16.
    int         m_state = 0;
    int         m_n = 0;
    int         m_good = 0;
    logic [1:0] m_rate = 2'b00;
    logic [8:0] m_set[$];

    task automatic model_rx(input logic k, input logic [7:0] d);
        if (k && d == 8'hBC) begin
            m_set.delete();
            m_set.push_back(9'h1BC);
        end else if (m_set.size() == 0) begin
            m_good = 0;
        end else begin
            m_set.push_back({k, d});
            if (k || (d != 8'h4A && d != 8'h45) || d != m_set[1][7:0]) begin
                m_set.delete();
                m_good = 0;
            end else if (m_set.size() == 16) begin
                if (m_state == 4 && d == 8'h4A) m_good = 0;
                else if (m_good < 8) m_good++;
                m_set.delete();
            end
        end
    endtask

    always @(posedge sysclk or negedge pci_perst_n) begin
        int nxt;
        if (!pci_perst_n) begin
            m_state = 0; m_n = 0; m_good = 0; m_set.delete(); m_rate = 2'b00;
        end else begin
            if (simu_mode_pipe ? sim_pipe_pclk_in : 1'b1) begin
                nxt = m_state;
                case (m_state)
                    0: if (!test_in[5] && m_n + 1 >= (test_in[0] ? 4 : 16)) nxt = 1;
                    1: nxt = pci_rx ? 2 : 0;
                    2: if (!pci_rx || m_n + 1 >= 4096) nxt = 0;
                       else if (m_good >= 8) nxt = 4;
                    4: if (!pci_rx || m_n + 1 >= 4096) nxt = 0;
                       else if (m_good >= 8 && m_n / 16 >= 16) nxt = 15;
                    default: if (!pci_rx) nxt = 0;
                endcase
                if (nxt != m_state) begin
                    m_state = nxt; m_n = 0; m_good = 0; m_set.delete();
                end else begin
                    if (!(m_state == 0 && test_in[5])) m_n++;
                    if ((m_state == 2 || m_state == 4) && pif.pipe_rxvalid)
                        model_rx(pif.pipe_rxdatak, pif.pipe_rxdata);
                end
            end
            m_rate = (m_state == 15 && test_in[1]) ? 2'b01 : 2'b00;
        end
    end

    always @(negedge sysclk) begin
        logic [7:0] ed;
        logic       ek;
        if (cmp_en) begin
            ed = 8'h00; ek = 1'b0;
            if (m_state == 2 || m_state == 4) begin
                if (m_n % 16 == 0) begin ed = 8'hBC; ek = 1'b1; end
                else ed = (m_state == 4) ? 8'h45 : 8'h4A;
            end
            chk("ltssmstate", sim_ltssmstate, m_state);
            chk("link_up", link_up, (m_state == 15));
            chk("pci_tx", pci_tx, (m_state > 1));
            chk("rate", sim_pipe_rate, m_rate);
            chk("txdata", pif.pipe_txdata, ed);
            chk("txdatak", pif.pipe_txdatak, ek);
        end
    end

    // ---------------- directed sequence ----------------
    task automatic step();
        @(posedge sysclk);
        #2;
    endtask

    task automatic wait_state(input logic [4:0] code, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (sim_ltssmstate == code) break;
            step();
        end
        checks++;
        if (i == budget) begin
            errors++;
            $display("FAIL %s: state %0h, wanted %0h within %0d cycles", name, sim_ltssmstate, code, budget);
        end
    endtask

    task automatic run_len(input logic [4:0] code, input int budget, output int n);
        n = 0;
        while (sim_ltssmstate == code && n < budget) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        pci_perst_n = 1'b0; test_in = '0; simu_mode_pipe = 1'b0; pci_rx = 1'b0;
        step(); step();
        cmp_en = 1'b1;
        step();
        chk("reset_state", sim_ltssmstate, 5'h00);
        chk("reset_link_up", link_up, 1'b0);
        chk("reset_txdata", pif.pipe_txdata, 8'h00);

        // Fast quiet with no far end: 00 for 4 ticks, 01 for one, back to 00.
        test_in = 32'h1;
        pci_perst_n = 1'b1;
        wait_state(5'h01, 50, "quiet_exit");
        wait_state(5'h00, 10, "active_fallback");
        run_len(5'h00, 100, n);
        chk("fast_quiet_len", n, 4);
        chk("pci_tx_detect", pci_tx, 1'b0);
        run_len(5'h01, 100, n);
        chk("detect_active_len", n, 1);

        // Full training with normal quiet.
        test_in = 32'h0; pci_rx = 1'b1; bfm_mode = 1;
        wait_state(5'h02, 200, "to_polling_active");
        chk("pa_sym0", {pif.pipe_txdatak, pif.pipe_txdata}, 9'h1BC);
        step();
        chk("pa_sym1", {pif.pipe_txdatak, pif.pipe_txdata}, 9'h04A);
        wait_state(5'h04, 1000, "to_polling_config");
        chk("pc_sym0", {pif.pipe_txdatak, pif.pipe_txdata}, 9'h1BC);
        step();
        chk("pc_sym1", {pif.pipe_txdatak, pif.pipe_txdata}, 9'h045);
        bfm_mode = 2;
        wait_state(5'h0F, 1000, "to_l0");
        chk("l0_link_up", link_up, 1'b1);
        chk("l0_txdata", pif.pipe_txdata, 8'h00);

        // TS1 injected in config, late enough that the tx TS2 minimum is met:
        // L0 must wait for 8 fresh TS2 after it.
        pci_rx = 1'b0;
        wait_state(5'h00, 10, "l0_drop");
        pci_rx = 1'b1; bfm_mode = 1;
        wait_state(5'h04, 1000, "retrain_config");
        for (int i = 0; i < 12; i++) bfm_q.push_back(2);
        bfm_q.push_back(1);
        bfm_mode = 2;
        wait_state(5'h0F, 1500, "retrain_l0");
        chk("ts2_after_ts1", ts2_since_ts1, 8);

        // No received sets: polling times out after exactly 4096 ticks.
        pci_rx = 1'b0;
        wait_state(5'h00, 10, "l0_drop2");
        bfm_mode = 0; pci_rx = 1'b1;
        wait_state(5'h02, 100, "to_polling_idle");
        run_len(5'h02, 5000, n);
        chk("poll_timeout_len", n, 4096);
        chk("poll_timeout_state", sim_ltssmstate, 5'h00);

        // Hold in quiet.
        test_in = 32'h21;
        repeat (40) step();
        chk("hold_quiet", sim_ltssmstate, 5'h00);

        // Strobed symbols: everything scales by 4.
        simu_mode_pipe = 1'b1; test_in = 32'h1; pci_rx = 1'b0;
        wait_state(5'h01, 200, "simu_quiet_exit");
        wait_state(5'h00, 20, "simu_fallback");
        run_len(5'h00, 200, n);
        chk("simu_quiet_len", n, 16);
        run_len(5'h01, 200, n);
        chk("simu_active_len", n, 4);
        pci_rx = 1'b1; test_in = 32'h2; bfm_mode = 1;
        wait_state(5'h02, 400, "simu_polling_active");
        wait_state(5'h04, 2000, "simu_polling_config");
        bfm_mode = 2;
        wait_state(5'h0F, 4000, "simu_l0");
        chk("gen2_rate", sim_pipe_rate, 2'b01);
        test_in = 32'h0;
        step();
        chk("gen1_rate", sim_pipe_rate, 2'b00);

        // Reset mid-L0 clears outputs immediately.
        pci_perst_n = 1'b0;
        #1;
        chk("rst_state", sim_ltssmstate, 5'h00);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_pci_tx", pci_tx, 1'b0);
        chk("rst_rate", sim_pipe_rate, 2'b00);
        chk("rst_tx", {pif.pipe_txdatak, pif.pipe_txdata}, 9'h000);
        repeat (3) step();
        pci_perst_n = 1'b1;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
